gc_unit: RTL and testbench
==========================

Name: gc_unit

Overview:
- Owns the global counter (gc) that every core's next-unit reads and post-increments to claim work items.
- Sits directly upstream of each core's next-unit.
- Arbitrates the per-core gc_req handshakes round-robin and grants at most one per cycle.
- Broadcasts the current counter value on a shared bus, which the granted core consumes in the same cycle.
- Advances the counter on each grant; the master can load or park it.

Parameters:
- N_CORE, 4, number of cores requesting the counter (≥2).
- GC_WIDTH, 16, counter width; matches the gc input width of the next-unit.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  N_CORE  gc_req.valid from each core's next-unit
- req_ready  output  N_CORE  gc_req.ready to each core; one-hot or zero
- gc  output  GC_WIDTH  current counter value, broadcast to all cores
- set_valid  input  1  master load strobe
- set_value  input  GC_WIDTH  value to load
- clear  input  1  return to IDLE, i.e. stop serving requests
- active  output  1  high in ACTIVE state
- grant_count  output  GC_WIDTH  grants since last set; wraps

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the posedge of clk.
- Reset values: state=IDLE, counter=0, gc=0, rr_ptr=0, grant_count=0, active=0, req_ready=0.
- States:
  - IDLE: req_ready all 0; gc still shows the counter.
  - ACTIVE: requests are served.
- Transitions:
  - IDLE→ACTIVE on set_valid.
  - ACTIVE→IDLE on clear (without set_valid).
  - set_valid and clear in the same cycle: set wins; go to or stay in ACTIVE.
  - reset overrides everything.
- Load: on set_valid, counter<=set_value and grant_count<=0 next edge, in either state.
- Grant (combinational, same cycle as req_valid):
  - Only in ACTIVE and only when set_valid=0 and clear=0.
  - Scan cores rr_ptr, rr_ptr+1, … mod N_CORE; the first with req_valid=1 gets req_ready=1; all others get 0.
  - req_ready may depend on req_valid; req_valid never depends on req_ready (next-unit contract).
- Handshake: a grant means req_valid[i]&&req_ready[i].
  - The granted core samples gc in that cycle (zero-latency read).
  - Next edge: counter<=counter+1 (mod 2^GC_WIDTH), grant_count<=grant_count+1, rr_ptr<=(i+1) mod N_CORE.
- No grant: counter, grant_count and rr_ptr hold.
- gc is a registered output: it equals counter, so a new value is visible exactly one cycle after a grant. No bypass.
- Withdrawal: a core may drop req_valid without a grant (its failure flush); no state changes, and the slot is not reserved.
- Wrap-around: counter 2^GC_WIDTH-1 + grant → 0, with no flag. rr_ptr N_CORE-1 → 0.
- Fairness: a continuously requesting core is granted within N_CORE cycles.
- Set and request in the same cycle: no grant that cycle; the requester retries and sees set_value next cycle.
- Reset mid-operation: an in-flight grant in the reset cycle does not advance the counter. The next-unit is flushed by the same reset.

Test Plan:
- Reset then idle request: reset 1 cycle; req_valid=4'b0001 → req_ready=0, gc=0, active=0 for 5 cycles.
- Load and single core: set_valid with set_value=100; then core 2 requests for 3 consecutive cycles → gc reads 100,101,102 in the grant cycles; gc=103 after; grant_count=3.
- Round-robin all-request: after set 0, req_valid=4'b1111 for 8 cycles → grant order 0,1,2,3,0,1,2,3; one-hot every cycle; gc 0..7.
- Pointer skip: rr_ptr=1, req_valid=4'b1001 → grant core 3, then core 0 next cycle; rr_ptr becomes 1.
- Set collides with request: ACTIVE, counter=50; core 1 requests and set_valid=1 with set_value=7 in the same cycle → no grant; next cycle core 1 granted with gc=7; counter=8 after.
- Wrap and clear: set 16'hFFFF; one grant → gc=0 next cycle. Assert clear → active=0 and req_ready=0 despite req_valid=4'b1111. Assert reset with a pending request → counter=0 and no increment.

Source files
------------

// File: rtl/gc_unit_if.sv
// Bus between gc_unit and the cores' next-units: request handshake,
// counter broadcast and master load/clear controls.
interface gc_unit_if #(
    parameter int unsigned N_CORE   = 4,
    parameter int unsigned GC_WIDTH = 16
);
    logic [N_CORE-1:0]   req_valid;
    logic [N_CORE-1:0]   req_ready;
    logic [GC_WIDTH-1:0] gc;
    logic                set_valid;
    logic [GC_WIDTH-1:0] set_value;
    logic                clear;
    logic                active;
    logic [GC_WIDTH-1:0] grant_count;

    modport master (
        output req_valid, set_valid, set_value, clear,
        input  req_ready, gc, active, grant_count
    );

    modport slave (
        input  req_valid, set_valid, set_value, clear,
        output req_ready, gc, active, grant_count
    );
endinterface

// File: rtl/gc_unit.sv
// Global work counter: round-robin grants one core per cycle, which reads gc
// in the grant cycle; the counter advances on the following edge.
module gc_unit #(
    parameter int unsigned N_CORE   = 4,
    parameter int unsigned GC_WIDTH = 16
) (
    input logic      clk,
    input logic      reset,
    gc_unit_if.slave bus
);
    localparam int unsigned PTR_W = (N_CORE > 1) ? $clog2(N_CORE) : 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    state_e              state_q, state_d;
    logic [GC_WIDTH-1:0] counter_q, counter_d;
    logic [GC_WIDTH-1:0] gcnt_q, gcnt_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                serve;
    logic                grant;
    logic [PTR_W-1:0]    grant_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            gcnt_q    <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            gcnt_q    <= gcnt_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.set_valid) state_d = ACTIVE;
            ACTIVE:  if (!bus.set_valid && bus.clear) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A load or clear in the same cycle suppresses granting so the
    // requester retries against the new counter value.
    assign serve = (state_q == ACTIVE) && !bus.set_valid && !bus.clear;

    always_comb begin
        int unsigned idx;
        grant     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N_CORE; k++) begin
            idx = (32'(rr_ptr_q) + k) % N_CORE;
            if (serve && !grant && bus.req_valid[idx[PTR_W-1:0]]) begin
                grant     = 1'b1;
                grant_idx = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        counter_d = counter_q;
        gcnt_d    = gcnt_q;
        rr_ptr_d  = rr_ptr_q;
        if (bus.set_valid) begin
            counter_d = bus.set_value;
            gcnt_d    = '0;
        end else if (grant) begin
            counter_d = counter_q + 1'b1;
            gcnt_d    = gcnt_q + 1'b1;
            rr_ptr_d  = (grant_idx == PTR_W'(N_CORE - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant) bus.req_ready[grant_idx] = 1'b1;
        bus.active = (state_q == ACTIVE);
    end

    assign bus.gc          = counter_q;
    assign bus.grant_count = gcnt_q;
endmodule

// File: tb/tb_gc_unit.sv
// Bench for gc_unit: a reference model pushes per-cycle expectations into a
// scoreboard that a negedge monitor pops; tasks add directed checks.
module tb_gc_unit;
    logic clk;
    logic reset;

    gc_unit_if #(.N_CORE(4), .GC_WIDTH(16)) bus ();

    gc_unit #(.N_CORE(4), .GC_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ready;
        logic [15:0] gc;
        logic [15:0] gcnt;
        logic        active;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state and the stimulus of the current cycle.
    logic        m_active;
    logic [15:0] m_cnt;
    logic [15:0] m_gcnt;
    int          m_ptr;
    logic [3:0]  cur_rv;
    logic        cur_sv;
    logic [15:0] cur_val;
    logic        cur_clr;
    logic        cur_rst;
    logic [3:0]  cur_exp_rdy;

    function automatic logic [3:0] model_ready(input logic [3:0] rv, input logic sv, input logic clr);
        if (!m_active || sv || clr) return 4'b0000;
        for (int off = 0; off < 4; off++) begin
            int c;
            c = (m_ptr + off) % 4;
            if (rv[c]) return 4'b0001 << c;
        end
        return 4'b0000;
    endfunction

    task automatic drive(input logic [3:0] rv, input logic sv, input logic [15:0] val,
                         input logic clr, input logic rst);
        exp_t e;
        bus.req_valid = rv;
        bus.set_valid = sv;
        bus.set_value = val;
        bus.clear     = clr;
        reset         = rst;
        cur_rv = rv; cur_sv = sv; cur_val = val; cur_clr = clr; cur_rst = rst;
        e.ready  = model_ready(rv, sv, clr);
        e.gc     = m_cnt;
        e.gcnt   = m_gcnt;
        e.active = m_active;
        cur_exp_rdy = e.ready;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        if (cur_rst) begin
            m_active = 1'b0; m_cnt = '0; m_gcnt = '0; m_ptr = 0;
        end else begin
            if (cur_sv) begin
                m_cnt = cur_val; m_gcnt = '0; m_active = 1'b1;
            end else if (cur_exp_rdy != 4'b0000) begin
                m_cnt  = m_cnt + 16'd1;
                m_gcnt = m_gcnt + 16'd1;
                for (int c = 0; c < 4; c++)
                    if (cur_exp_rdy[c]) m_ptr = (c + 1) % 4;
            end
            if (cur_clr && !cur_sv) m_active = 1'b0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (bus.req_ready !== e.ready) begin
                n_err++;
                $display("FAIL sb_req_ready t=%0t got=%b exp=%b", $time, bus.req_ready, e.ready);
            end
            n_cmp++;
            if (bus.gc !== e.gc) begin
                n_err++;
                $display("FAIL sb_gc t=%0t got=%0d exp=%0d", $time, bus.gc, e.gc);
            end
            n_cmp++;
            if (bus.active !== e.active) begin
                n_err++;
                $display("FAIL sb_active t=%0t got=%b exp=%b", $time, bus.active, e.active);
            end
            n_cmp++;
            if (bus.grant_count !== e.gcnt) begin
                n_err++;
                $display("FAIL sb_grant_count t=%0t got=%0d exp=%0d", $time, bus.grant_count, e.gcnt);
            end
        end
    end

    task automatic test_reset();
        drive(4'b0000, 1'b0, 16'd0, 1'b0, 1'b1); tick();
        for (int i = 0; i < 5; i++) begin
            drive(4'b0001, 1'b0, 16'd0, 1'b0, 1'b0);
            n_cmp++;
            if (bus.req_ready !== 4'b0000 || bus.gc !== 16'd0 || bus.active !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle got ready=%b gc=%0d active=%b exp 0000/0/0",
                         bus.req_ready, bus.gc, bus.active);
            end
            tick();
        end
    endtask

    task automatic test_load_single();
        drive(4'b0000, 1'b1, 16'd100, 1'b0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b0, 16'd0, 1'b0, 1'b0);
            n_cmp++;
            if (bus.req_ready !== 4'b0100 || bus.gc !== 16'(100 + i)) begin
                n_err++;
                $display("FAIL load_single_grant got ready=%b gc=%0d exp 0100/%0d",
                         bus.req_ready, bus.gc, 100 + i);
            end
            tick();
        end
        drive(4'b0000, 1'b0, 16'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.gc !== 16'd103 || bus.grant_count !== 16'd3) begin
            n_err++;
            $display("FAIL load_single_after got gc=%0d gcnt=%0d exp 103/3", bus.gc, bus.grant_count);
        end
        tick();
    endtask

    task automatic test_round_robin();
        drive(4'b0000, 1'b0, 16'd0, 1'b0, 1'b1); tick();
        drive(4'b0000, 1'b1, 16'd0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 1'b0, 16'd0, 1'b0, 1'b0);
            n_cmp++;
            if (bus.req_ready !== (4'b0001 << (i % 4)) || bus.gc !== 16'(i)) begin
                n_err++;
                $display("FAIL round_robin cyc=%0d got ready=%b gc=%0d exp %b/%0d",
                         i, bus.req_ready, bus.gc, 4'b0001 << (i % 4), i);
            end
            tick();
        end
    endtask

    task automatic test_pointer_skip();
        drive(4'b0000, 1'b0, 16'd0, 1'b0, 1'b1); tick();
        drive(4'b0000, 1'b1, 16'd0, 1'b0, 1'b0); tick();
        drive(4'b0001, 1'b0, 16'd0, 1'b0, 1'b0); tick();
        drive(4'b1001, 1'b0, 16'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL ptr_skip_first got=%b exp=1000", bus.req_ready);
        end
        tick();
        drive(4'b1001, 1'b0, 16'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL ptr_skip_second got=%b exp=0001", bus.req_ready);
        end
        tick();
        drive(4'b1111, 1'b0, 16'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL ptr_skip_ptr1 got=%b exp=0010", bus.req_ready);
        end
        tick();
    endtask

    task automatic test_set_collision();
        drive(4'b0000, 1'b1, 16'd50, 1'b0, 1'b0); tick();
        drive(4'b0010, 1'b1, 16'd7, 1'b0, 1'b0);
        n_cmp++;
        if (bus.req_ready !== 4'b0000 || bus.gc !== 16'd50) begin
            n_err++;
            $display("FAIL set_collide got ready=%b gc=%0d exp 0000/50", bus.req_ready, bus.gc);
        end
        tick();
        drive(4'b0010, 1'b0, 16'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.req_ready !== 4'b0010 || bus.gc !== 16'd7) begin
            n_err++;
            $display("FAIL set_retry got ready=%b gc=%0d exp 0010/7", bus.req_ready, bus.gc);
        end
        tick();
        drive(4'b0000, 1'b0, 16'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.gc !== 16'd8) begin
            n_err++;
            $display("FAIL set_after got gc=%0d exp 8", bus.gc);
        end
        tick();
    endtask

    task automatic test_wrap_clear();
        drive(4'b0000, 1'b1, 16'hFFFF, 1'b0, 1'b0); tick();
        drive(4'b0001, 1'b0, 16'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.gc !== 16'hFFFF || bus.req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL wrap_grant got ready=%b gc=%h exp 0001/ffff", bus.req_ready, bus.gc);
        end
        tick();
        drive(4'b0000, 1'b0, 16'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.gc !== 16'd0 || bus.grant_count !== 16'd1) begin
            n_err++;
            $display("FAIL wrap_after got gc=%0d gcnt=%0d exp 0/1", bus.gc, bus.grant_count);
        end
        tick();
        drive(4'b1111, 1'b0, 16'd0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL clear_cycle got ready=%b exp 0000", bus.req_ready);
        end
        tick();
        drive(4'b1111, 1'b0, 16'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.active !== 1'b0 || bus.req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL cleared got active=%b ready=%b exp 0/0000", bus.active, bus.req_ready);
        end
        tick();
        drive(4'b0000, 1'b1, 16'd5, 1'b1, 1'b0); tick();
        drive(4'b0000, 1'b0, 16'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.active !== 1'b1 || bus.gc !== 16'd5) begin
            n_err++;
            $display("FAIL set_beats_clear got active=%b gc=%0d exp 1/5", bus.active, bus.gc);
        end
        tick();
        drive(4'b0000, 1'b1, 16'd20, 1'b0, 1'b0); tick();
        drive(4'b0001, 1'b0, 16'd0, 1'b0, 1'b1); tick();
        drive(4'b0000, 1'b0, 16'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.gc !== 16'd0 || bus.grant_count !== 16'd0 || bus.active !== 1'b0) begin
            n_err++;
            $display("FAIL reset_inflight got gc=%0d gcnt=%0d active=%b exp 0/0/0",
                     bus.gc, bus.grant_count, bus.active);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(4'b0000, 1'b1, 16'hFFF0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 60; i++) begin
            logic [3:0] rv;
            logic       sv, clr;
            rv  = 4'($urandom);
            sv  = ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 19) == 0);
            drive(rv, sv, 16'($urandom), clr, 1'b0);
            n_cmp++;
            if (!$onehot0(bus.req_ready) || (bus.req_ready & ~rv) != 4'b0000) begin
                n_err++;
                $display("FAIL b2b_onehot cyc=%0d got ready=%b valid=%b", i, bus.req_ready, rv);
            end
            tick();
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.set_valid = 1'b0;
        bus.set_value = '0;
        bus.clear     = 1'b0;
        m_active = 1'b0; m_cnt = '0; m_gcnt = '0; m_ptr = 0;
        cur_rst = 1'b1; cur_exp_rdy = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_single();
        test_round_robin();
        test_pointer_skip();
        test_set_collision();
        test_wrap_clear();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain got=%0d entries exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
